// File: rtl/m_muldiv_pkg.sv
// Shared constants and types for the iterative RV32M multiply/divide unit.
package m_muldiv_pkg;

  // RV32M funct3 encodings
  localparam logic [2:0] F3_MUL    = 3'b000;
  localparam logic [2:0] F3_MULH   = 3'b001;
  localparam logic [2:0] F3_MULHSU = 3'b010;
  localparam logic [2:0] F3_MULHU  = 3'b011;
  localparam logic [2:0] F3_DIV    = 3'b100;
  localparam logic [2:0] F3_DIVU   = 3'b101;
  localparam logic [2:0] F3_REM    = 3'b110;
  localparam logic [2:0] F3_REMU   = 3'b111;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CALC = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  // Which iteration the shared step block performs
  typedef enum logic {
    MD_MUL = 1'b0,
    MD_DIV = 1'b1
  } mode_e;

endpackage

// File: rtl/m_muldiv_step.sv
// One combinational iteration, shared by the multiply and divide paths.
// The accumulator is {hi, lo}:
//   multiply: hi = running partial product, lo collects product bits shifted in
//             from hi; i_bit is the current multiplier LSB.
//   divide:   hi = partial remainder, lo = quotient bits; i_bit is the next
//             dividend bit (MSB-first).
module m_muldiv_step
  import m_muldiv_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic [2*XLEN-1:0] i_acc,
  input  logic [XLEN-1:0]   i_opnd,
  input  logic              i_bit,
  input  mode_e             i_mode,
  output logic [2*XLEN-1:0] o_acc
);

  logic [XLEN:0] w_sum;
  logic [XLEN:0] w_rem_sh;
  logic [XLEN:0] w_trial;

  // Multiply: conditional add then shift right (carry becomes the new MSB).
  // Divide: shift in dividend bit, trial subtract, restore on borrow.
  always_comb begin
    w_sum    = {1'b0, i_acc[2*XLEN-1:XLEN]} + (i_bit ? {1'b0, i_opnd} : '0);
    w_rem_sh = {i_acc[2*XLEN-1:XLEN], i_bit};
    w_trial  = w_rem_sh - {1'b0, i_opnd};
    if (i_mode == MD_MUL)
      o_acc = {w_sum, i_acc[XLEN-1:1]};
    else if (w_trial[XLEN])
      o_acc = {w_rem_sh[XLEN-1:0], i_acc[XLEN-2:0], 1'b0};
    else
      o_acc = {w_trial[XLEN-1:0], i_acc[XLEN-2:0], 1'b1};
  end

endmodule

// File: rtl/m_muldiv_unit.sv
// Multi-cycle RV32M multiply/divide unit: one bit per cycle, valid/ready on
// both request and response, sign fixup applied on the edge into DONE.
module m_muldiv_unit
  import m_muldiv_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic            w_clk,
  input  logic            w_rst_n,
  input  logic            w_req_valid,
  output logic            w_req_ready,
  input  logic [2:0]      w_funct3,
  input  logic [XLEN-1:0] w_in1,
  input  logic [XLEN-1:0] w_in2,
  input  logic            w_flush,
  output logic            w_resp_valid,
  input  logic            w_resp_ready,
  output logic [XLEN-1:0] w_out,
  output logic            w_busy
);

  localparam int CW = $clog2(XLEN) + 1;

  state_e              r_state;
  state_e              w_state_nxt;
  logic [2:0]          r_f3;
  logic                r_neg;
  logic [XLEN-1:0]     r_opa;   // multiplier (shifts right) or dividend (shifts left)
  logic [XLEN-1:0]     r_opb;   // multiplicand or divisor
  logic [XLEN-1:0]     r_out;
  logic [2*XLEN-1:0]   r_acc;
  logic [CW-1:0]       r_cnt;

  logic                w_is_div;
  logic                w_sa;
  logic                w_sb;
  logic                w_sign;
  logic [XLEN-1:0]     w_a_abs;
  logic [XLEN-1:0]     w_b_abs;
  logic                w_dz;
  logic                w_ovf;
  logic                w_special;
  logic [XLEN-1:0]     w_special_res;
  logic                w_accept;
  logic                w_last;
  logic                w_step_bit;
  mode_e               w_mode;
  logic [2*XLEN-1:0]   w_acc_nxt;
  logic [XLEN-1:0]     w_hi;
  logic [XLEN-1:0]     w_lo;
  logic [XLEN-1:0]     w_res;

  // Operand preparation and special-case detection for the accept edge
  always_comb begin
    w_is_div = w_funct3[2];
    w_sa     = w_in1[XLEN-1] & ((w_funct3 == F3_MULH) | (w_funct3 == F3_MULHSU) |
                                (w_funct3 == F3_DIV)  | (w_funct3 == F3_REM));
    w_sb     = w_in2[XLEN-1] & ((w_funct3 == F3_MULH) | (w_funct3 == F3_DIV) |
                                (w_funct3 == F3_REM));
    // remainder follows the dividend; everything else is the xor of operand signs
    w_sign   = (w_funct3 == F3_REM) ? w_sa : (w_sa ^ w_sb);
    w_a_abs  = w_sa ? (-w_in1) : w_in1;
    w_b_abs  = w_sb ? (-w_in2) : w_in2;
    w_dz     = w_is_div & (w_in2 == '0);
    w_ovf    = ((w_funct3 == F3_DIV) | (w_funct3 == F3_REM)) &
               (w_in1 == {1'b1, {(XLEN-1){1'b0}}}) & (&w_in2);
    w_special = w_dz | w_ovf;
    if (w_dz)
      w_special_res = w_funct3[1] ? w_in1 : '1;
    else
      w_special_res = w_funct3[1] ? '0 : w_in1;
    w_accept = w_req_valid & (r_state == ST_IDLE) & ~w_flush;
    w_last   = (r_state == ST_CALC) & (r_cnt == CW'(1));
  end

  assign w_step_bit = r_f3[2] ? r_opa[XLEN-1] : r_opa[0];
  assign w_mode     = r_f3[2] ? MD_DIV : MD_MUL;

  m_muldiv_step #(.XLEN(XLEN)) u_step (
    .i_acc  (r_acc),
    .i_opnd (r_opb),
    .i_bit  (w_step_bit),
    .i_mode (w_mode),
    .o_acc  (w_acc_nxt)
  );

  // Final result select with sign fixup on the last iteration's output.
  // High half of a 2*XLEN negate is ~hi plus the carry out of ~lo + 1.
  always_comb begin
    w_hi = w_acc_nxt[2*XLEN-1:XLEN];
    w_lo = w_acc_nxt[XLEN-1:0];
    case (r_f3)
      F3_MUL:                         w_res = w_lo;
      F3_MULH, F3_MULHSU, F3_MULHU:   w_res = r_neg ? (~w_hi + XLEN'(w_lo == '0)) : w_hi;
      F3_DIV, F3_DIVU:                w_res = r_neg ? (-w_lo) : w_lo;
      default:                        w_res = r_neg ? (-w_hi) : w_hi;
    endcase
  end

  // State register
  always_ff @(posedge w_clk or negedge w_rst_n) begin
    if (!w_rst_n) r_state <= ST_IDLE;
    else          r_state <= w_state_nxt;
  end

  // Next-state logic; flush overrides everything
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE: if (w_accept) w_state_nxt = w_special ? ST_DONE : ST_CALC;
      ST_CALC: if (r_cnt == CW'(1)) w_state_nxt = ST_DONE;
      ST_DONE: if (w_resp_ready) w_state_nxt = ST_IDLE;
      default: w_state_nxt = ST_IDLE;
    endcase
    if (w_flush) w_state_nxt = ST_IDLE;
  end

  // Datapath: load on accept, iterate in CALC, capture result on last step
  always_ff @(posedge w_clk or negedge w_rst_n) begin
    if (!w_rst_n) begin
      r_f3  <= '0;
      r_neg <= 1'b0;
      r_opa <= '0;
      r_opb <= '0;
      r_out <= '0;
      r_acc <= '0;
      r_cnt <= '0;
    end else if (w_accept) begin
      r_f3  <= w_funct3;
      r_neg <= w_sign;
      r_opa <= w_is_div ? w_a_abs : w_b_abs;
      r_opb <= w_is_div ? w_b_abs : w_a_abs;
      r_acc <= '0;
      r_cnt <= CW'(XLEN);
      if (w_special) r_out <= w_special_res;
    end else if ((r_state == ST_CALC) && !w_flush) begin
      r_acc <= w_acc_nxt;
      r_cnt <= r_cnt - CW'(1);
      r_opa <= r_f3[2] ? (r_opa << 1) : (r_opa >> 1);
      if (w_last) r_out <= w_res;
    end
  end

  assign w_req_ready  = (r_state == ST_IDLE);
  assign w_busy       = (r_state != ST_IDLE);
  assign w_resp_valid = (r_state == ST_DONE);
  assign w_out        = r_out;

endmodule
